triwave_sweep_ctrl: RTL

- Frequency-sweep sequencer for the triangle-wave generator.
- Drives the generator's enable and `Scale` inputs and watches its duty output to find period boundaries.
- Steps `Scale` from a programmed start value to a programmed end value, dwelling a programmed number of triangle periods at each value.
- Sits between the switch/register front end and the generator. It is the only writer of `Scale` and enable while busy.

---
 rtl/triwave_pkg.sv | 18 +
 rtl/duty_boundary_detect.sv | 20 ++
 rtl/triwave_sweep_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/triwave_pkg.sv
// Shared types and helpers for the triangle-wave generator front ends.
package triwave_pkg;

  localparam int unsigned SCALE_W_DFLT = 6;
  localparam int unsigned SCALE_MIN    = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } sweep_state_t;

  // Zero is not a usable scale/step/dwell; promote it to the minimum.
  function automatic int unsigned clamp_min(input int unsigned v);
    return (v == 0) ? SCALE_MIN : v;
  endfunction

endpackage

// File: rtl/duty_boundary_detect.sv
// Flags the falling-to-zero transition of the generator duty value (one triangle period boundary).
module duty_boundary_detect #(
  parameter int unsigned W = 6
) (
  input  logic         sysclk,
  input  logic         rst_n,
  input  logic [W-1:0] duty_in,
  output logic         boundary
);

  logic [W-1:0] prev_duty;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) prev_duty <= '0;
    else        prev_duty <= duty_in;
  end

  assign boundary = (prev_duty != '0) && (duty_in == '0);

endmodule

// File: rtl/triwave_sweep_ctrl.sv
// Frequency-sweep sequencer for the triangle-wave generator.
// Define TRIWAVE_SWEEP_BIDIR_EN for endless ping-pong sweeping instead of one-shot.
module triwave_sweep_ctrl
  import triwave_pkg::*;
#(
  parameter int unsigned SCALE_W = SCALE_W_DFLT,
  parameter int unsigned DWELL_W = 8
) (
  input  logic               sysclk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [SCALE_W-1:0] cfg_start_scale,
  input  logic [SCALE_W-1:0] cfg_end_scale,
  input  logic [SCALE_W-1:0] cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [SCALE_W-1:0] duty_in,
  output logic               gen_enable,
  output logic [SCALE_W-1:0] gen_scale,
  output logic               busy,
  output logic               done,
  output logic               period_tick
);

  sweep_state_t       state;
  logic [SCALE_W-1:0] end_l, step_l;
  logic [DWELL_W-1:0] dwell_l, dwell_cnt;
  logic               dir_up;
  logic               boundary;
  logic [SCALE_W-1:0] cs_c, ce_c, st_c;
  logic [DWELL_W-1:0] dw_c;
`ifdef TRIWAVE_SWEEP_BIDIR_EN
  logic [SCALE_W-1:0] start_l;
`endif

  duty_boundary_detect #(.W(SCALE_W)) u_bdet (
    .sysclk   (sysclk),
    .rst_n    (rst_n),
    .duty_in  (duty_in),
    .boundary (boundary)
  );

  // One step toward tgt, computed with a carry/borrow bit so it can never pass tgt.
  function automatic logic [SCALE_W-1:0] step_toward(
    input logic [SCALE_W-1:0] cur,
    input logic [SCALE_W-1:0] stp,
    input logic [SCALE_W-1:0] tgt,
    input logic               up
  );
    logic [SCALE_W:0] sum, diff;
    sum  = {1'b0, cur} + {1'b0, stp};
    diff = {1'b0, cur} - {1'b0, stp};
    if (up) return (sum > {1'b0, tgt}) ? tgt : sum[SCALE_W-1:0];
    return (diff[SCALE_W] || (diff < {1'b0, tgt})) ? tgt : diff[SCALE_W-1:0];
  endfunction

  always_comb begin
    cs_c = SCALE_W'(clamp_min(32'(cfg_start_scale)));
    ce_c = SCALE_W'(clamp_min(32'(cfg_end_scale)));
    st_c = SCALE_W'(clamp_min(32'(cfg_step)));
    dw_c = DWELL_W'(clamp_min(32'(cfg_dwell)));
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      gen_enable  <= 1'b0;
      gen_scale   <= SCALE_W'(SCALE_MIN);
      busy        <= 1'b0;
      done        <= 1'b0;
      period_tick <= 1'b0;
      end_l       <= SCALE_W'(SCALE_MIN);
      step_l      <= SCALE_W'(SCALE_MIN);
      dwell_l     <= DWELL_W'(1);
      dwell_cnt   <= '0;
      dir_up      <= 1'b1;
`ifdef TRIWAVE_SWEEP_BIDIR_EN
      start_l     <= SCALE_W'(SCALE_MIN);
`endif
    end else begin
      done        <= 1'b0;
      period_tick <= 1'b0;
      if (abort) begin
        state      <= ST_IDLE;
        busy       <= 1'b0;
        gen_enable <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state      <= ST_SYNC;
              busy       <= 1'b1;
              gen_enable <= 1'b1;
              gen_scale  <= cs_c;
              end_l      <= ce_c;
              step_l     <= st_c;
              dwell_l    <= dw_c;
              dir_up     <= (ce_c >= cs_c);
`ifdef TRIWAVE_SWEEP_BIDIR_EN
              start_l    <= cs_c;
`endif
            end
          end
          ST_SYNC: begin
            if (boundary) begin
              state     <= ST_RUN;
              dwell_cnt <= '0;
            end
          end
          ST_RUN: begin
            if (boundary) begin
              period_tick <= 1'b1;
              if (dwell_cnt == dwell_l - DWELL_W'(1)) begin
                dwell_cnt <= '0;
                if (gen_scale == end_l) begin
`ifdef TRIWAVE_SWEEP_BIDIR_EN
                  // Turn around: old start becomes the new target, first step taken now.
                  start_l   <= end_l;
                  end_l     <= start_l;
                  dir_up    <= !dir_up;
                  gen_scale <= step_toward(gen_scale, step_l, start_l, !dir_up);
`else
                  state      <= ST_IDLE;
                  busy       <= 1'b0;
                  gen_enable <= 1'b0;
                  done       <= 1'b1;
`endif
                end else begin
                  gen_scale <= step_toward(gen_scale, step_l, end_l, dir_up);
                end
              end else begin
                dwell_cnt <= dwell_cnt + DWELL_W'(1);
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
